// File: rtl/nios_namedisplay_switch_debounce.sv
// Slide-switch conditioner: per-bit synchroniser chain, independent debounce counters,
// and registered one-cycle rise/fall/change pulses feeding the switch PIO in_port.
module nios_namedisplay_switch_debounce #(
    parameter int               WIDTH         = 2,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = 500000,
    parameter int               CNT_W         = 19,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] clean_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             changed_r;
    logic [WIDTH-1:0] clean_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;

    // Only the last synchroniser stage is ever consumed by the debounce logic.
    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 is the only flop that samples the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Per-bit debounce next state; any return to equality discards progress.
    always_comb begin
        clean_nxt_s = clean_r;
        rise_nxt_s  = {WIDTH{1'b0}};
        fall_nxt_s  = {WIDTH{1'b0}};
        cnt_nxt_s   = cnt_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == clean_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == TERM_CNT) begin
                cnt_nxt_s[i]   = {CNT_W{1'b0}};
                clean_nxt_s[i] = sync_s[i];
                rise_nxt_s[i]  = sync_s[i];
                fall_nxt_s[i]  = ~sync_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1'b1);
            end
        end
    end

    // Debounce state and pulse registers; pulses coincide with the new clean level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            clean_r   <= RESET_VAL;
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            clean_r   <= clean_nxt_s;
            rise_r    <= rise_nxt_s;
            fall_r    <= fall_nxt_s;
            changed_r <= |(rise_nxt_s | fall_nxt_s);
        end
    end

    assign sw_clean   = clean_r;
    assign sw_rise    = rise_r;
    assign sw_fall    = fall_r;
    assign sw_changed = changed_r;

endmodule

// File: tb/tb_nios_namedisplay_switch_debounce.sv
// Bench: directed vector table plus random holds, checked against a history-window model;
// a second instance with STABLE_CYCLES=1 covers the minimum-count corner.
module tb_nios_namedisplay_switch_debounce;

    logic       clk;
    logic       reset_n;
    logic [1:0] sw_raw;
    logic [1:0] c0, r0, f0, c1, r1, f1;
    logic       g0, g1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    nios_namedisplay_switch_debounce #(
        .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(3), .RESET_VAL(2'b00)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_clean(c0), .sw_rise(r0), .sw_fall(f0), .sw_changed(g0)
    );

    nios_namedisplay_switch_debounce #(
        .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(3), .RESET_VAL(2'b00)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_clean(c1), .sw_rise(r1), .sw_fall(f1), .sw_changed(g1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = instance with 4 stable cycles, index 1 = 1 stable cycle.
    logic [1:0] rawh  [2][16];
    logic [1:0] synch [2][16];
    int         rawn  [2];
    int         syncn [2];
    logic [1:0] m_clean [2];
    logic [1:0] m_rise  [2];
    logic [1:0] m_fall  [2];
    logic       m_chg   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rawn[k]    = 0;
            syncn[k]   = 0;
            m_clean[k] = 2'b00;
            m_rise[k]  = 2'b00;
            m_fall[k]  = 2'b00;
            m_chg[k]   = 1'b0;
        end
    endtask

    // A bit flips once the last st synchronised samples all disagree with the clean level.
    task automatic model_step(input int k, input int st, input logic [1:0] raw);
        logic [1:0] s;
        logic [1:0] nc;
        logic       mism;
        s = (rawn[k] >= 2) ? rawh[k][1] : 2'b00;
        for (int j = 15; j > 0; j--) synch[k][j] = synch[k][j-1];
        synch[k][0] = s;
        if (syncn[k] < 16) syncn[k]++;
        nc = m_clean[k];
        for (int b = 0; b < 2; b++) begin
            mism = (syncn[k] >= st);
            for (int j = 0; j < st; j++) begin
                if (synch[k][j][b] == m_clean[k][b]) mism = 1'b0;
            end
            if (mism) nc[b] = ~m_clean[k][b];
        end
        m_rise[k]  = nc & ~m_clean[k];
        m_fall[k]  = ~nc & m_clean[k];
        m_chg[k]   = |(m_rise[k] | m_fall[k]);
        m_clean[k] = nc;
        for (int j = 15; j > 0; j--) rawh[k][j] = rawh[k][j-1];
        rawh[k][0] = raw;
        if (rawn[k] < 16) rawn[k]++;
    endtask

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got={clean,rise,fall,chg}=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic apply(input logic [1:0] raw, input logic rst);
        sw_raw  = raw;
        reset_n = rst;
        if (!rst) model_reset();
        @(posedge clk);
        if (rst) begin
            model_step(0, 4, raw);
            model_step(1, 1, raw);
        end
        @(negedge clk);
        cyc++;
        check("model_st4", {c0, r0, f0, g0}, {m_clean[0], m_rise[0], m_fall[0], m_chg[0]});
        check("model_st1", {c1, r1, f1, g1}, {m_clean[1], m_rise[1], m_fall[1], m_chg[1]});
    endtask

    typedef struct {
        logic [1:0] raw;
        logic       rst;
        int         n;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] raw, input logic rst, input int n,
                       input logic [1:0] cl, input logic [1:0] ri, input logic [1:0] fa,
                       input logic ch);
        vec_t v;
        v.raw = raw; v.rst = rst; v.n = n; v.clean = cl; v.rise = ri; v.fall = fa; v.chg = ch;
        tbl.push_back(v);
    endtask

    initial begin
        logic [6:0] exp;
        logic [1:0] val;
        int         len;
        reset_n = 1'b0;
        sw_raw  = 2'b11;
        model_reset();
        @(negedge clk);

        // Reset release with switches held high
        add(2'b11, 1'b0, 3, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b1, 5, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b1, 1, 2'b11, 2'b11, 2'b00, 1'b1);
        add(2'b11, 1'b1, 3, 2'b11, 2'b00, 2'b00, 1'b0);
        // Both bits fall together
        add(2'b00, 1'b1, 5, 2'b11, 2'b00, 2'b00, 1'b0);
        add(2'b00, 1'b1, 1, 2'b00, 2'b00, 2'b11, 1'b1);
        add(2'b00, 1'b1, 3, 2'b00, 2'b00, 2'b00, 1'b0);
        // Bounce on bit0, 2-cycle dwell
        add(2'b01, 1'b1, 2, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b00, 1'b1, 2, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b01, 1'b1, 5, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b01, 1'b1, 1, 2'b01, 2'b01, 2'b00, 1'b1);
        add(2'b01, 1'b1, 3, 2'b01, 2'b00, 2'b00, 1'b0);
        // Glitch on bit1, one cycle short of acceptance
        add(2'b11, 1'b1, 3, 2'b01, 2'b00, 2'b00, 1'b0);
        add(2'b01, 1'b1, 6, 2'b01, 2'b00, 2'b00, 1'b0);
        // Simultaneous opposite changes
        add(2'b10, 1'b1, 5, 2'b01, 2'b00, 2'b00, 1'b0);
        add(2'b10, 1'b1, 1, 2'b10, 2'b10, 2'b01, 1'b1);
        add(2'b10, 1'b1, 3, 2'b10, 2'b00, 2'b00, 1'b0);
        // Return to 00, then reset in the middle of a count
        add(2'b00, 1'b1, 5, 2'b10, 2'b00, 2'b00, 1'b0);
        add(2'b00, 1'b1, 1, 2'b00, 2'b00, 2'b10, 1'b1);
        add(2'b00, 1'b1, 2, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b1, 4, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b1, 5, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b1, 1, 2'b11, 2'b11, 2'b00, 1'b1);
        add(2'b11, 1'b1, 2, 2'b11, 2'b00, 2'b00, 1'b0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                apply(tbl[i].raw, tbl[i].rst);
                check($sformatf("tbl%0d", i), {c0, r0, f0, g0},
                      {tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].chg});
            end
        end

        // Single-cycle acceptance: bit0 step shows up on the third cycle
        repeat (8) apply(2'b00, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            apply(2'b01, 1'b1);
            exp = (j < 3)  ? 7'b00_00_00_0 :
                  (j == 3) ? 7'b01_01_00_1 : 7'b01_00_00_0;
            check("st1_step", {c1, r1, f1, g1}, exp);
        end

        // Random holds of varying length with occasional reset pulses
        for (int b = 0; b < 60; b++) begin
            val = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            for (int r = 0; r < len; r++) begin
                apply(val, ($urandom_range(0, 59) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
